// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt controller sequencing logic.
package pic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAck1,
    StAck2
  } seq_state_e;

  localparam int unsigned NumLevels     = 8;
  localparam logic [2:0]  SpuriousLevel = 3'd7;

  function automatic logic [7:0] level_onehot(input logic [2:0] level);
    level_onehot = 8'b1 << level;
  endfunction

endpackage

// File: rtl/pic_priority_select.sv
// Rotating-priority arbiter: level priority_rotate+1 is highest, priority_rotate is lowest.
module pic_priority_select
  import pic_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [2:0] priority_rotate,
  output logic [7:0] onehot,
  output logic [2:0] level,
  output logic       valid
);

  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    for (int i = 0; i < NumLevels; i++) begin
      logic [2:0] idx;
      idx = 3'(priority_rotate + 3'(i + 1));
      if (!valid && irr[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
    onehot = valid ? level_onehot(level) : 8'h00;
  end

endmodule

// File: rtl/inta_sequencer.sv
// 8259-style INTA sequencer: two-pulse acknowledge, vector drive and EOI generation.
// Define INTA_SEQ_AUTO_EOI_EN to enable automatic EOI at the end of the acknowledge.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic [7:0] irr_masked,
  input  logic [2:0] priority_rotate,
  input  logic [4:0] vector_base,
  input  logic       aeoi_mode,
  input  logic       eoi_cmd_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic [7:0] highest_level_in_service,
  output logic       int_out,
  output logic [7:0] interrupt,
  output logic       in_service_flag,
  output logic [7:0] eoi,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  seq_state_e state_q;
  logic       sync1_q, sync2_q, hist_q;
  logic [2:0] level_q;
  logic       spurious_q;

  logic       inta_fall, inta_rise;
  logic [7:0] win_onehot;
  logic [2:0] win_level;
  logic       win_valid;
  logic [7:0] cmd_eoi, aeoi_eoi;

  pic_priority_select u_priority_select (
    .irr             (irr_masked),
    .priority_rotate (priority_rotate),
    .onehot          (win_onehot),
    .level           (win_level),
    .valid           (win_valid)
  );

  assign inta_fall = hist_q & ~sync2_q;
  assign inta_rise = ~hist_q & sync2_q;

  assign cmd_eoi = !eoi_cmd_valid ? 8'h00 :
                   eoi_specific   ? level_onehot(eoi_level) : highest_level_in_service;

`ifdef INTA_SEQ_AUTO_EOI_EN
  assign aeoi_eoi = (state_q == StAck2 && inta_rise && aeoi_mode && !spurious_q) ?
                    level_onehot(level_q) : 8'h00;
`else
  logic unused_aeoi;
  assign unused_aeoi = aeoi_mode ^ spurious_q;
  assign aeoi_eoi    = 8'h00;
`endif

  // Sync flops reset high so a fall is only seen after inta_n is observed high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      hist_q          <= 1'b1;
      level_q         <= 3'd0;
      spurious_q      <= 1'b0;
      int_out         <= 1'b0;
      interrupt       <= 8'h00;
      in_service_flag <= 1'b0;
      eoi             <= 8'h00;
      data_out        <= 8'h00;
      data_out_en     <= 1'b0;
    end else begin
      sync1_q         <= inta_n;
      sync2_q         <= sync1_q;
      hist_q          <= sync2_q;
      interrupt       <= 8'h00;
      in_service_flag <= 1'b0;
      eoi             <= cmd_eoi | aeoi_eoi;
      unique case (state_q)
        StIdle: begin
          int_out <= |irr_masked;
          if (inta_fall) begin
            level_q         <= win_valid ? win_level : SpuriousLevel;
            spurious_q      <= ~win_valid;
            interrupt       <= win_onehot;
            in_service_flag <= win_valid;
            int_out         <= 1'b0;
            state_q         <= StAck1;
          end
        end
        StAck1: begin
          int_out     <= 1'b0;
          data_out_en <= 1'b0;
          if (inta_fall) begin
            data_out    <= {vector_base, level_q};
            data_out_en <= 1'b1;
            state_q     <= StAck2;
          end
        end
        StAck2: begin
          int_out <= 1'b0;
          if (inta_rise) begin
            data_out    <= 8'h00;
            data_out_en <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed self-checking bench for inta_sequencer.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inta_n;
  logic [7:0] irr_masked;
  logic [2:0] priority_rotate;
  logic [4:0] vector_base;
  logic       aeoi_mode;
  logic       eoi_cmd_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [7:0] highest_level_in_service;
  logic       int_out;
  logic [7:0] interrupt;
  logic       in_service_flag;
  logic [7:0] eoi;
  logic [7:0] data_out;
  logic       data_out_en;

  int checks = 0;
  int errors = 0;

`ifdef INTA_SEQ_AUTO_EOI_EN
  localparam bit AeoiBuilt = 1'b1;
`else
  localparam bit AeoiBuilt = 1'b0;
`endif

  inta_sequencer u_dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .inta_n                   (inta_n),
    .irr_masked               (irr_masked),
    .priority_rotate          (priority_rotate),
    .vector_base              (vector_base),
    .aeoi_mode                (aeoi_mode),
    .eoi_cmd_valid            (eoi_cmd_valid),
    .eoi_specific             (eoi_specific),
    .eoi_level                (eoi_level),
    .highest_level_in_service (highest_level_in_service),
    .int_out                  (int_out),
    .interrupt                (interrupt),
    .in_service_flag          (in_service_flag),
    .eoi                      (eoi),
    .data_out                 (data_out),
    .data_out_en              (data_out_en)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b expected 0", int_out); end
    checks++; if (interrupt !== 8'h00) begin errors++; $display("FAIL reset_interrupt: got %h expected 00", interrupt); end
    checks++; if (data_out_en !== 1'b0) begin errors++; $display("FAIL reset_data_out_en: got %b expected 0", data_out_en); end
    checks++; if (eoi !== 8'h00) begin errors++; $display("FAIL reset_eoi: got %h expected 00", eoi); end
    rst_n = 1'b1;
    tick(2);
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", int_out); end
  endtask

  // rotate 7, irr 0000_0110 -> level 1, vector 0x41
  task automatic test_basic_ack();
    priority_rotate = 3'd7; irr_masked = 8'b0000_0110; vector_base = 5'b01000; aeoi_mode = 1'b0;
    tick(1);
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int_out_idle: got %b expected 1", int_out); end
    inta_n = 1'b0;
    tick(3);
    checks++; if (interrupt !== 8'b0000_0010) begin errors++; $display("FAIL basic_interrupt: got %h expected 02", interrupt); end
    checks++; if (in_service_flag !== 1'b1) begin errors++; $display("FAIL basic_isf: got %b expected 1", in_service_flag); end
    checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL basic_int_out_ack: got %b expected 0", int_out); end
    tick(1);
    checks++; if (interrupt !== 8'h00 || in_service_flag !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %h/%b expected 00/0", interrupt, in_service_flag); end
    inta_n = 1'b1;
    tick(3);
    checks++; if (data_out_en !== 1'b0 || int_out !== 1'b0) begin errors++; $display("FAIL basic_ack1_hold: got en=%b int=%b expected 0/0", data_out_en, int_out); end
    inta_n = 1'b0;
    tick(3);
    checks++; if (data_out_en !== 1'b1) begin errors++; $display("FAIL basic_data_out_en: got %b expected 1", data_out_en); end
    checks++; if (data_out !== 8'h41) begin errors++; $display("FAIL basic_data_out: got %h expected 41", data_out); end
    inta_n = 1'b1;
    tick(3);
    checks++; if (data_out_en !== 1'b0) begin errors++; $display("FAIL basic_en_drop: got %b expected 0", data_out_en); end
    checks++; if (eoi !== 8'h00) begin errors++; $display("FAIL basic_no_aeoi: got %h expected 00", eoi); end
    tick(1);
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL basic_back_idle: got %b expected 1", int_out); end
  endtask

  // rotate 1, irr 0000_0011 -> order 2..7,0,1 so level 0 wins
  task automatic test_rotate();
    priority_rotate = 3'd1; irr_masked = 8'b0000_0011; vector_base = 5'b10101;
    inta_n = 1'b0;
    tick(3);
    checks++; if (interrupt !== 8'h01) begin errors++; $display("FAIL rotate_interrupt: got %h expected 01", interrupt); end
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    checks++; if (data_out !== 8'hA8) begin errors++; $display("FAIL rotate_data_out: got %h expected a8", data_out); end
    inta_n = 1'b1; tick(4);
  endtask

  task automatic test_spurious();
    irr_masked = 8'h00; vector_base = 5'b01000; aeoi_mode = 1'b1;
    inta_n = 1'b0;
    tick(3);
    checks++; if (in_service_flag !== 1'b0 || interrupt !== 8'h00) begin errors++; $display("FAIL spurious_isf: got %b/%h expected 0/00", in_service_flag, interrupt); end
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    checks++; if (data_out !== 8'h47) begin errors++; $display("FAIL spurious_data_out: got %h expected 47", data_out); end
    inta_n = 1'b1; tick(3);
    checks++; if (eoi !== 8'h00) begin errors++; $display("FAIL spurious_no_aeoi: got %h expected 00", eoi); end
    tick(1);
    aeoi_mode = 1'b0;
  endtask

  task automatic test_aeoi();
    logic [7:0] exp_eoi;
    exp_eoi = AeoiBuilt ? 8'h08 : 8'h00;
    priority_rotate = 3'd7; irr_masked = 8'b0000_1000; aeoi_mode = 1'b1;
    inta_n = 1'b0; tick(3);
    checks++; if (interrupt !== 8'h08) begin errors++; $display("FAIL aeoi_interrupt: got %h expected 08", interrupt); end
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(3);
    checks++; if (eoi !== exp_eoi) begin errors++; $display("FAIL aeoi_pulse: got %h expected %h", eoi, exp_eoi); end
    tick(1);
    checks++; if (eoi !== 8'h00) begin errors++; $display("FAIL aeoi_pulse_width: got %h expected 00", eoi); end
    aeoi_mode = 1'b0;
  endtask

  task automatic test_eoi_cmd();
    highest_level_in_service = 8'h20;
    eoi_cmd_valid = 1'b1; eoi_specific = 1'b0;
    tick(1);
    eoi_cmd_valid = 1'b0;
    checks++; if (eoi !== 8'h20) begin errors++; $display("FAIL eoi_nonspecific: got %h expected 20", eoi); end
    tick(1);
    checks++; if (eoi !== 8'h00) begin errors++; $display("FAIL eoi_pulse_width: got %h expected 00", eoi); end
    eoi_cmd_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd6;
    tick(1);
    eoi_cmd_valid = 1'b0;
    checks++; if (eoi !== 8'h40) begin errors++; $display("FAIL eoi_specific: got %h expected 40", eoi); end
    tick(1);
  endtask

  // Command EOI lands on the same edge as the AEOI pulse.
  task automatic test_eoi_coincident();
    logic [7:0] exp_eoi;
    exp_eoi = AeoiBuilt ? 8'h09 : 8'h01;
    priority_rotate = 3'd7; irr_masked = 8'b0000_1000; aeoi_mode = 1'b1;
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(2);
    eoi_cmd_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0;
    tick(1);
    eoi_cmd_valid = 1'b0;
    checks++; if (eoi !== exp_eoi) begin errors++; $display("FAIL eoi_coincident: got %h expected %h", eoi, exp_eoi); end
    tick(2);
    aeoi_mode = 1'b0;
  endtask

  task automatic test_reset_mid_ack();
    priority_rotate = 3'd7; irr_masked = 8'b0000_0100; vector_base = 5'b00011;
    inta_n = 1'b0; tick(3);
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    checks++; if (data_out_en !== 1'b1) begin errors++; $display("FAIL midack_en_before: got %b expected 1", data_out_en); end
    rst_n = 1'b0;
    #2;
    checks++; if (data_out_en !== 1'b0) begin errors++; $display("FAIL midack_en_async: got %b expected 0", data_out_en); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midack_data_async: got %h expected 00", data_out); end
    inta_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL midack_idle_int_out: got %b expected 1", int_out); end
    inta_n = 1'b0; tick(3);
    checks++; if (interrupt !== 8'h04) begin errors++; $display("FAIL midack_restart: got %h expected 04", interrupt); end
    inta_n = 1'b1; tick(3);
    inta_n = 1'b0; tick(3);
    checks++; if (data_out !== 8'h1A) begin errors++; $display("FAIL midack_vector: got %h expected 1a", data_out); end
    inta_n = 1'b1; tick(4);
  endtask

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; irr_masked = 8'h00; priority_rotate = 3'd7;
    vector_base = 5'd0; aeoi_mode = 1'b0; eoi_cmd_valid = 1'b0; eoi_specific = 1'b0;
    eoi_level = 3'd0; highest_level_in_service = 8'h00;
    test_reset();
    test_basic_ack();
    test_rotate();
    test_spurious();
    test_aeoi();
    test_eoi_cmd();
    test_eoi_coincident();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
